// File: rtl/spi_byte_scheduler.sv
// Byte scheduler between TX/RX streams and an SPI core: queues bytes, sequences one transfer
// at a time and captures replies. Optional SPI_SCHED_TIMEOUT_EN adds a per-phase wait limit.
module spi_byte_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic [7:0] o_spi_data,
  output logic       o_trans_en,
  input  logic       i_spi_ss,
  input  logic [7:0] i_spi_rdata,
  input  logic       i_err_clr,
  output logic       o_busy,
  output logic [4:0] o_tx_level,
  output logic       o_rx_overflow,
  output logic       o_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (TIMEOUT_CYCLES < 16) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_cfg
    $error("spi_byte_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StWaitLow, StWaitHigh, StCapture
  } state_e;

  state_e state_q, state_d;
  logic [7:0] spi_data_q, spi_data_d;
  logic       trans_en_q, trans_en_d;
  logic       rx_ovf_q, rx_ovf_d, ovf_set;
  logic [1:0] ss_sync_q;
  logic       ss_s;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, rx_push, rx_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  assign tx_push = i_tx_valid && !tx_full;
  assign rx_pop  = i_rx_ready && !rx_empty;
  assign ss_s    = ss_sync_q[1];

  always_ff @(posedge i_sys_clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= i_tx_data;
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= i_spi_rdata;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      ss_sync_q  <= 2'b11;
      state_q    <= StIdle;
      spi_data_q <= 8'h00;
      trans_en_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      ss_sync_q  <= {ss_sync_q[0], i_spi_ss};
      state_q    <= state_d;
      spi_data_q <= spi_data_d;
      trans_en_q <= trans_en_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d, tmo_hit;
  assign tmo_hit = ((state_q == StWaitLow) || (state_q == StWaitHigh)) && (tmo_cnt_q == TmoLast);
`endif

  always_comb begin
    state_d    = state_q;
    spi_data_d = spi_data_q;
    trans_en_d = trans_en_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    ovf_set    = 1'b0;
    case (state_q)
      StIdle:  if (!tx_empty) state_d = StLoad;
      StLoad: begin
        spi_data_d = tx_mem[tx_rd_q[AW-1:0]];
        tx_pop     = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        trans_en_d = 1'b1;
        state_d    = StWaitLow;
      end
      StWaitLow: begin
        if (!ss_s) begin
          trans_en_d = 1'b0;
          state_d    = StWaitHigh;
        end
      end
      StWaitHigh: if (ss_s) state_d = StCapture;
      StCapture: begin
        if (rx_full) ovf_set = 1'b1;
        else         rx_push = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef SPI_SCHED_TIMEOUT_EN
    // An expired wait abandons the transfer regardless of what SS is doing this cycle.
    if (tmo_hit) begin
      trans_en_d = 1'b0;
      state_d    = StIdle;
    end
`endif
    rx_ovf_d = ovf_set || (rx_ovf_q && !i_err_clr);
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  always_comb begin
    tmo_cnt_d = 16'h0000;
    if (((state_q == StWaitLow) || (state_q == StWaitHigh)) && (state_d == state_q)) begin
      tmo_cnt_d = tmo_cnt_q + 16'h0001;
    end
    tmo_d = tmo_hit || (tmo_q && !i_err_clr);
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      tmo_cnt_q <= 16'h0000;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_timeout = tmo_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_tx_ready    = !tx_full;
  assign o_rx_valid    = !rx_empty;
  assign o_rx_data     = rx_mem[rx_rd_q[AW-1:0]];
  assign o_spi_data    = spi_data_q;
  assign o_trans_en    = trans_en_q;
  assign o_busy        = (state_q != StIdle);
  assign o_tx_level    = 5'(tx_wr_q - tx_rd_q);
  assign o_rx_overflow = rx_ovf_q;

endmodule

// File: tb/tb_spi_byte_scheduler.sv
// Scoreboard bench: an SPI core model answers each transfer; expected TX/RX byte streams
// are queued at stimulus time and checked by independent monitor processes.
module tb_spi_byte_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready = 1'b0;
  logic [7:0] o_spi_data;
  logic       o_trans_en;
  logic       i_spi_ss = 1'b1;
  logic [7:0] i_spi_rdata = 8'h00;
  logic       i_err_clr = 1'b0;
  logic       o_busy;
  logic [4:0] o_tx_level;
  logic       o_rx_overflow;
  logic       o_timeout;

  always #5 clk = ~clk;

  spi_byte_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .o_spi_data(o_spi_data), .o_trans_en(o_trans_en),
    .i_spi_ss(i_spi_ss), .i_spi_rdata(i_spi_rdata), .i_err_clr(i_err_clr),
    .o_busy(o_busy), .o_tx_level(o_tx_level),
    .o_rx_overflow(o_rx_overflow), .o_timeout(o_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int pulses = 0;
  int rx_pops = 0;
  bit xfer_active = 0, exp_ovf = 0, drop_next = 0, core_mute = 0, fixed_mode = 1, rx_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_chk(input string name, input int n, input int limit);
    n_cmp++;
    if (n >= limit) begin
      n_err++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    i_tx_valid = 1'b1;
    i_tx_data  = b;
    while (!o_tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    bound_chk("tx_accept", n, 2000);
    tx_exp.push_back(b);
    @(posedge clk);
    #1 i_tx_valid = 1'b0;
  endtask

  task automatic wait_done(input bit need_rx_empty);
    int n = 0;
    while ((o_busy || o_tx_level != 0 || xfer_active || (need_rx_empty && rx_exp.size() != 0))
           && n < 20000) begin
      @(negedge clk);
      n++;
    end
    bound_chk("idle_wait", n, 20000);
    @(posedge clk);
    #1;
  endtask

  // SPI core model: each rising transfer request consumes the next expected TX byte.
  initial begin
    int lo, hi, n;
    logic [7:0] rsp;
    forever begin
      @(negedge clk);
      if (o_trans_en && !core_mute && !rst) begin
        xfer_active = 1;
        pulses++;
        if (tx_exp.size() == 0) chk("tx_unexpected", o_trans_en, 1'b0);
        else                    chk("spi_data", o_spi_data, tx_exp.pop_front());
        lo  = fixed_mode ? 10 : $urandom_range(2, 20);
        hi  = fixed_mode ? 80 : $urandom_range(4, 40);
        rsp = fixed_mode ? 8'h3c : 8'($urandom);
        repeat (lo) @(negedge clk);
        chk("trans_en_hold", o_trans_en, 1'b1);
        i_spi_rdata = rsp;
        i_spi_ss    = 1'b0;
        n = 0;
        while (o_trans_en && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("trans_en_drop", o_trans_en, 1'b0);
        repeat (hi) @(negedge clk);
        i_spi_ss = 1'b1;
        if (drop_next)                drop_next = 0;
        else if (rx_exp.size() < DEPTH) rx_exp.push_back(rsp);
        else                          exp_ovf = 1;
        xfer_active = 0;
      end
    end
  end

  // RX consumer and monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        i_rx_ready = 1'b0;
      end else begin
        i_rx_ready = rx_mode && ($urandom_range(0, 3) != 0);
        if (i_rx_ready && o_rx_valid) begin
          rx_pops++;
          if (rx_exp.size() == 0) chk("rx_unexpected", o_rx_valid, 1'b0);
          else                    chk("rx_data", o_rx_data, rx_exp.pop_front());
        end
      end
    end
  end

  initial begin
    int p0, k, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", o_tx_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_tx_level", o_tx_level, 5'd0);
    chk("rst_rx_valid", o_rx_valid, 1'b0);
    chk("rst_trans_en", o_trans_en, 1'b0);
    chk("rst_spi_data", o_spi_data, 8'h00);
    chk("rst_overflow", o_rx_overflow, 1'b0);
    chk("rst_timeout", o_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte with fixed SS timing and reply.
    fixed_mode = 1;
    p0 = pulses;
    push_byte(8'ha5);
    k = 0;
    while (!o_trans_en && k < 10) begin
      @(posedge clk);
      #1 k++;
    end
    chk("start_latency", k, 3);
    wait_done(0);
    chk("single_pulses", pulses - p0, 1);
    chk("single_spi_data", o_spi_data, 8'ha5);
    chk("single_rx_valid", o_rx_valid, 1'b1);
    chk("single_rx_data", o_rx_data, 8'h3c);
    rx_mode = 1;
    wait_done(1);
    chk("single_drained", o_rx_valid, 1'b0);

    // Burst of six: FIFO fills to four while the first transfer is in flight.
    fixed_mode = 0;
    p0 = pulses;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    chk("burst_tx_ready", o_tx_ready, 1'b0);
    chk("burst_tx_level", o_tx_level, 5'd4);
    push_byte(8'h06);
    wait_done(1);
    chk("burst_pulses", pulses - p0, 6);
    chk("burst_drained", o_rx_valid, 1'b0);

    // Overflow: no consumer, five transfers into a four-entry RX FIFO.
    rx_mode = 0;
    exp_ovf = 0;
    p0 = rx_pops;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    wait_done(0);
    chk("ovf_flag", o_rx_overflow, exp_ovf);
    chk("ovf_rx_valid", o_rx_valid, 1'b1);
    rx_mode = 1;
    wait_done(1);
    chk("ovf_held", rx_pops - p0, DEPTH);
    chk("ovf_sticky", o_rx_overflow, 1'b1);
    @(negedge clk);
    i_err_clr = 1'b1;
    @(posedge clk);
    #1 i_err_clr = 1'b0;
    chk("ovf_cleared", o_rx_overflow, 1'b0);
    exp_ovf = 0;

    // Randomized traffic with a live consumer.
    p0 = pulses;
    repeat (20) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      push_byte(8'($urandom));
    end
    wait_done(1);
    chk("rand_pulses", pulses - p0, 20);
    chk("rand_no_ovf", o_rx_overflow, exp_ovf);

`ifdef SPI_SCHED_TIMEOUT_EN
    core_mute = 1;
    push_byte(8'h77);
    void'(tx_exp.pop_back());
    n = 0;
    while (!o_trans_en && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    k = 0;
    while (!o_timeout && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    chk("timeout_cycles", k, TMO);
    chk("timeout_trans_en", o_trans_en, 1'b0);
    chk("timeout_idle", o_busy, 1'b0);
    core_mute = 0;
    @(negedge clk);
    i_err_clr = 1'b1;
    @(posedge clk);
    #1 i_err_clr = 1'b0;
    chk("timeout_cleared", o_timeout, 1'b0);
`else
    chk("timeout_tied", o_timeout, 1'b0);
`endif

    // Reset in the middle of a transfer, after SS has gone low.
    fixed_mode = 1;
    drop_next  = 1;
    push_byte(8'h5a);
    n = 0;
    while (i_spi_ss && n < 200) begin
      @(negedge clk);
      n++;
    end
    bound_chk("ss_low_wait", n, 200);
    repeat (4) @(posedge clk);
    chk("pre_reset_busy", o_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_trans_en", o_trans_en, 1'b0);
    chk("mid_rst_spi_data", o_spi_data, 8'h00);
    chk("mid_rst_tx_ready", o_tx_ready, 1'b1);
    chk("mid_rst_tx_level", o_tx_level, 5'd0);
    chk("mid_rst_rx_valid", o_rx_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (xfer_active && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_rx_valid", o_rx_valid, 1'b0);
    chk("post_rst_busy", o_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
